// File: rtl/axi4_lite_wr_queue_if.sv
// Producer, flush and AXI4-Lite write-master signals of axi4_lite_wr_queue.
// wr_count is present only when AXI4_LITE_WR_QUEUE_STATS_EN is defined.
interface axi4_lite_wr_queue_if #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic [AW-1:0] in_addr;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          flush;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_valid;
   logic          wr_ready;
   logic [LW-1:0] level;
   logic          busy;
`ifdef AXI4_LITE_WR_QUEUE_STATS_EN
   logic [15:0]   wr_count;

   modport master (
      input  in_addr, in_data, in_valid, flush, wr_ready,
      output in_ready, wr_addr, wr_data, wr_valid, level, busy,
      output wr_count
   );

   modport slave (
      output in_addr, in_data, in_valid, flush, wr_ready,
      input  in_ready, wr_addr, wr_data, wr_valid, level, busy,
      input  wr_count
   );
`else
   modport master (
      input  in_addr, in_data, in_valid, flush, wr_ready,
      output in_ready, wr_addr, wr_data, wr_valid, level, busy
   );

   modport slave (
      output in_addr, in_data, in_valid, flush, wr_ready,
      input  in_ready, wr_addr, wr_data, wr_valid, level, busy
   );
`endif
endinterface

// File: rtl/axi4_lite_wr_queue.sv
// Circular write queue feeding an AXI4-Lite write master, one write in flight.
// Define AXI4_LITE_WR_QUEUE_STATS_EN to add the saturating wr_count output.
module axi4_lite_wr_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   axi4_lite_wr_queue_if.master bus
);
   localparam int IW = $clog2(DEPTH);
   localparam int LW = IW + 1;
   localparam logic [IW:0]   PONE = 1;
   localparam logic [IW-1:0] IONE = 1;
   localparam logic [LW-1:0] LONE = 1;

   typedef enum logic {IDLE, ISSUE} state_e;

   state_e        state_q, state_d;
   logic [IW:0]   wr_ptr_q, wr_ptr_d;
   logic [IW:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic [AW-1:0] addr_mem_q [DEPTH];
   logic [DW-1:0] data_mem_q [DEPTH];

   logic          full, empty, push, pop;
   logic [IW-1:0] wr_idx, rd_idx, nx_idx;
   logic [LW-1:0] level;

   assign wr_idx = wr_ptr_q[IW-1:0];
   assign rd_idx = rd_ptr_q[IW-1:0];
   assign nx_idx = rd_idx + IONE;
   assign level  = wr_ptr_q - rd_ptr_q;
   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_ptr_q[IW] != rd_ptr_q[IW]) &&
                   (wr_idx == rd_idx);

   assign bus.in_ready = !full && !bus.flush;
   assign push = bus.in_valid && bus.in_ready;
   assign pop  = (state_q == ISSUE) && bus.wr_ready;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      addr_d   = addr_q;
      data_d   = data_q;
      if (push) wr_ptr_d = wr_ptr_q + PONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PONE;
      // Flush keeps the in-flight head unless it retires this cycle.
      if (bus.flush) begin
         if (state_q == ISSUE && !pop) wr_ptr_d = rd_ptr_q + PONE;
         else                          wr_ptr_d = rd_ptr_d;
      end
      unique case (state_q)
         IDLE: begin
            if (!empty && !bus.flush) begin
               state_d = ISSUE;
               addr_d  = addr_mem_q[rd_idx];
               data_d  = data_mem_q[rd_idx];
            end
         end
         ISSUE: begin
            if (pop) begin
               if (bus.flush || wr_ptr_d == rd_ptr_d) begin
                  state_d = IDLE;
               end else if (level == LONE) begin
                  addr_d = bus.in_addr;
                  data_d = bus.in_data;
               end else begin
                  addr_d = addr_mem_q[nx_idx];
                  data_d = data_mem_q[nx_idx];
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem_q[wr_idx] <= bus.in_addr;
         data_mem_q[wr_idx] <= bus.in_data;
      end
   end

   assign bus.wr_valid = (state_q == ISSUE);
   assign bus.busy     = (state_q == ISSUE);
   assign bus.wr_addr  = addr_q;
   assign bus.wr_data  = data_q;
   assign bus.level    = level;

`ifdef AXI4_LITE_WR_QUEUE_STATS_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (pop && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign bus.wr_count = cnt_q;
`endif
endmodule

// File: tb/tb_axi4_lite_wr_queue.sv
// Directed self-checking bench for axi4_lite_wr_queue (DEPTH=4, AW=DW=32).
// wr_count checks are compiled in with AXI4_LITE_WR_QUEUE_STATS_EN.
module tb_axi4_lite_wr_queue;
   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   axi4_lite_wr_queue_if #(.DEPTH(4), .AW(32), .DW(32)) q_if ();

   axi4_lite_wr_queue #(.DEPTH(4), .AW(32), .DW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (q_if.master)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_one(input logic [31:0] a, input logic [31:0] d);
      q_if.in_addr  = a;
      q_if.in_data  = d;
      q_if.in_valid = 1'b1;
      tick();
      q_if.in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      q_if.in_addr  = '0;
      q_if.in_data  = '0;
      q_if.in_valid = 1'b0;
      q_if.flush    = 1'b0;
      q_if.wr_ready = 1'b0;
      tick();
      tick();
      chk("rst_wr_valid", 64'(q_if.wr_valid), 64'd0);
      chk("rst_busy",     64'(q_if.busy),     64'd0);
      chk("rst_level",    64'(q_if.level),    64'd0);
      chk("rst_in_ready", 64'(q_if.in_ready), 64'd1);
      chk("rst_wr_addr",  64'(q_if.wr_addr),  64'd0);
      chk("rst_wr_data",  64'(q_if.wr_data),  64'd0);
      rst = 1'b0;
      tick();

      // single write, one cycle latency, held until wr_ready
      push_one(32'h0000_0010, 32'hDEAD_BEEF);
      chk("s_level_push", 64'(q_if.level),    64'd1);
      chk("s_valid_n",    64'(q_if.wr_valid), 64'd0);
      tick();
      chk("s_valid_n1",   64'(q_if.wr_valid), 64'd1);
      chk("s_busy",       64'(q_if.busy),     64'd1);
      chk("s_addr",       64'(q_if.wr_addr),  64'h10);
      chk("s_data",       64'(q_if.wr_data),  64'hDEAD_BEEF);
      tick();
      chk("s_hold_valid", 64'(q_if.wr_valid), 64'd1);
      chk("s_hold_data",  64'(q_if.wr_data),  64'hDEAD_BEEF);
      q_if.wr_ready = 1'b1;
      tick();
      q_if.wr_ready = 1'b0;
      chk("s_level_pop",  64'(q_if.level),    64'd0);
      chk("s_valid_pop",  64'(q_if.wr_valid), 64'd0);

      // fill to full, fifth offer refused, drain back to back
      for (int i = 0; i < 4; i++) push_one(32'(4 * i), 32'h100 + 32'(i));
      chk("f_level",    64'(q_if.level),    64'd4);
      chk("f_in_ready", 64'(q_if.in_ready), 64'd0);
      push_one(32'h0000_0010, 32'h0000_0999);
      chk("f_5th_level", 64'(q_if.level),   64'd4);
      q_if.wr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("f_valid", 64'(q_if.wr_valid), 64'd1);
         chk("f_addr",  64'(q_if.wr_addr),  64'(4 * i));
         chk("f_data",  64'(q_if.wr_data),  64'h100 + 64'(i));
         tick();
      end
      q_if.wr_ready = 1'b0;
      chk("f_end_valid", 64'(q_if.wr_valid), 64'd0);
      chk("f_end_level", 64'(q_if.level),    64'd0);

      // push and pop together at level 2
      push_one(32'h20, 32'hA0);
      push_one(32'h24, 32'hA4);
      chk("pp_level2", 64'(q_if.level),   64'd2);
      chk("pp_head",   64'(q_if.wr_addr), 64'h20);
      q_if.wr_ready = 1'b1;
      push_one(32'h28, 32'hA8);
      chk("pp_level_same", 64'(q_if.level),    64'd2);
      chk("pp_next_valid", 64'(q_if.wr_valid), 64'd1);
      chk("pp_next_addr",  64'(q_if.wr_addr),  64'h24);
      tick();
      chk("pp_addr3",  64'(q_if.wr_addr), 64'h28);
      chk("pp_data3",  64'(q_if.wr_data), 64'hA8);
      tick();
      q_if.wr_ready = 1'b0;
      chk("pp_drained", 64'(q_if.level), 64'd0);

      // push and pop together at level 1
      push_one(32'h60, 32'hB0);
      tick();
      q_if.wr_ready = 1'b1;
      push_one(32'h64, 32'hB4);
      chk("byp_valid", 64'(q_if.wr_valid), 64'd1);
      chk("byp_addr",  64'(q_if.wr_addr),  64'h64);
      chk("byp_data",  64'(q_if.wr_data),  64'hB4);
      chk("byp_level", 64'(q_if.level),    64'd1);
      tick();
      q_if.wr_ready = 1'b0;
      chk("byp_done", 64'(q_if.level), 64'd0);

      // wr_ready in IDLE is ignored
      q_if.wr_ready = 1'b1;
      push_one(32'h70, 32'hC0);
      q_if.wr_ready = 1'b0;
      chk("idle_rdy_level", 64'(q_if.level), 64'd1);
      tick();
      chk("idle_rdy_addr",  64'(q_if.wr_addr), 64'h70);
      chk("idle_rdy_lvl2",  64'(q_if.level),   64'd1);
      q_if.wr_ready = 1'b1;
      tick();
      q_if.wr_ready = 1'b0;

      // flush with an entry in flight
      push_one(32'h30, 32'hD0);
      push_one(32'h34, 32'hD4);
      push_one(32'h38, 32'hD8);
      chk("fl_level3", 64'(q_if.level), 64'd3);
      q_if.flush = 1'b1;
      #1;
      chk("fl_in_ready", 64'(q_if.in_ready), 64'd0);
      tick();
      q_if.flush = 1'b0;
      chk("fl_level1", 64'(q_if.level),    64'd1);
      chk("fl_valid",  64'(q_if.wr_valid), 64'd1);
      chk("fl_addr",   64'(q_if.wr_addr),  64'h30);
      q_if.wr_ready = 1'b1;
      tick();
      q_if.wr_ready = 1'b0;
      chk("fl_done_level", 64'(q_if.level),    64'd0);
      chk("fl_done_valid", 64'(q_if.wr_valid), 64'd0);

      // flush and wr_ready together
      push_one(32'h40, 32'hE0);
      push_one(32'h44, 32'hE4);
      q_if.flush    = 1'b1;
      q_if.wr_ready = 1'b1;
      tick();
      q_if.flush    = 1'b0;
      q_if.wr_ready = 1'b0;
      chk("flr_level", 64'(q_if.level),    64'd0);
      chk("flr_valid", 64'(q_if.wr_valid), 64'd0);
      tick();
      chk("flr_stay_idle", 64'(q_if.wr_valid), 64'd0);

      // reset mid-transaction
      push_one(32'h50, 32'hF0);
      push_one(32'h54, 32'hF4);
      push_one(32'h58, 32'hF8);
      chk("mr_level3", 64'(q_if.level),    64'd3);
      chk("mr_issue",  64'(q_if.wr_valid), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_level",    64'(q_if.level),    64'd0);
      chk("mr_valid",    64'(q_if.wr_valid), 64'd0);
      chk("mr_in_ready", 64'(q_if.in_ready), 64'd1);
      chk("mr_busy",     64'(q_if.busy),     64'd0);

`ifdef AXI4_LITE_WR_QUEUE_STATS_EN
      chk("st_rst0", 64'(q_if.wr_count), 64'd0);
      for (int i = 0; i < 5; i++) begin
         push_one(32'h80 + 32'(4 * i), 32'(i));
         tick();
         q_if.wr_ready = 1'b1;
         tick();
         q_if.wr_ready = 1'b0;
      end
      chk("st_count5", 64'(q_if.wr_count), 64'd5);
      push_one(32'h90, 32'h9);
      q_if.flush = 1'b1;
      tick();
      q_if.flush = 1'b0;
      chk("st_flush_keep", 64'(q_if.wr_count), 64'd5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("st_rst_clear", 64'(q_if.wr_count), 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
